// File: rtl/maze_actor_mover_pkg.sv
// maze_actor_mover_pkg
// Shared types and defaults for the maze actor movement engine.
//   direction_t : 2-bit heading, UP=0 RIGHT=1 DOWN=2 LEFT=3
//   reverse()   : opposite heading (flip bit 1)
//   state_t     : movement engine FSM states
//   *_DEF       : default map geometry
package maze_actor_mover_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } direction_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN_RD,
    ST_TURN_WAIT,
    ST_MOVE_RD,
    ST_MOVE_WAIT,
    ST_ADVANCE,
    ST_DONE
  } state_t;

  localparam int MAP_W_TILES_DEF = 28;
  localparam int MAP_H_TILES_DEF = 36;
  localparam int MAP_STRIDE_DEF  = 32;
  localparam int TILE_SIZE_DEF   = 8;

  // Opposite headings differ only in bit 1 of the encoding.
  function automatic direction_t reverse(input direction_t d);
    return direction_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/maze_neighbour_addr.sv
// maze_neighbour_addr
// Combinational lookup of the tile adjacent to a pixel position.
//   x, y : pixel position (tile taken from the upper bits)
//   dir  : direction of the neighbour to look at
//   addr : map word address of the neighbour tile (tx + ty*MAP_STRIDE)
//   oob  : neighbour lies above the top row or below the bottom row;
//          the caller treats it as a wall and issues no read
// Horizontal neighbours wrap around the map width (tunnel).
module maze_neighbour_addr
  import maze_actor_mover_pkg::*;
#(
  parameter int MAP_W_TILES = MAP_W_TILES_DEF,
  parameter int MAP_H_TILES = MAP_H_TILES_DEF,
  parameter int MAP_STRIDE  = MAP_STRIDE_DEF,
  parameter int TILE_SIZE   = TILE_SIZE_DEF,
  parameter int POS_W       = 9,
  parameter int ADDR_W      = $clog2(MAP_STRIDE * MAP_H_TILES)
) (
  input  logic [POS_W-1:0]  x,
  input  logic [POS_W-1:0]  y,
  input  direction_t        dir,
  output logic [ADDR_W-1:0] addr,
  output logic              oob
);

  localparam int TS_LOG2 = $clog2(TILE_SIZE);
  localparam int T_W     = POS_W - TS_LOG2;

  logic [T_W-1:0] tx;
  logic [T_W-1:0] ty;
  logic [T_W-1:0] ntx;
  logic [T_W-1:0] nty;

  assign tx = x[POS_W-1:TS_LOG2];
  assign ty = y[POS_W-1:TS_LOG2];

  always_comb begin
    ntx = tx;
    nty = ty;
    oob = 1'b0;
    unique case (dir)
      DIR_UP: begin
        if (ty == '0) oob = 1'b1;
        else          nty = ty - 1'b1;
      end
      DIR_DOWN: begin
        if (32'(ty) + 32'd1 >= 32'(MAP_H_TILES)) oob = 1'b1;
        else                                     nty = ty + 1'b1;
      end
      DIR_LEFT: begin
        ntx = (tx == '0) ? T_W'(MAP_W_TILES - 1) : tx - 1'b1;
      end
      DIR_RIGHT: begin
        ntx = (32'(tx) + 32'd1 >= 32'(MAP_W_TILES)) ? '0 : tx + 1'b1;
      end
    endcase
    addr = ADDR_W'(ntx) + ADDR_W'(nty) * ADDR_W'(MAP_STRIDE);
  end

endmodule

// File: rtl/maze_actor_mover.sv
// maze_actor_mover
// Per-frame movement engine for N maze actors sharing one map read port.
// Each frame_stb walks every actor through up to speed[i] one-pixel steps;
// every step is: optional turn check, move check, advance.
//   clk, rst_n         : clock, asynchronous active-low reset
//   frame_stb          : starts an update pass (dropped while busy)
//   want_valid/want_dir: per-actor buffered direction requests
//   speed              : steps per frame per actor, sampled at pass start
//   load_stb/idx/x/y   : teleport an actor (honoured only when idle)
//   map_rd_en/map_addr : map read request; map_data returns next cycle
//   x_pos/y_pos/cur_dir/stopped : registered per-actor state
//   busy/pass_done/frame_overrun: pass status
module maze_actor_mover
  import maze_actor_mover_pkg::*;
#(
  parameter int N_ACTORS    = 4,
  parameter int MAP_W_TILES = MAP_W_TILES_DEF,
  parameter int MAP_H_TILES = MAP_H_TILES_DEF,
  parameter int MAP_STRIDE  = MAP_STRIDE_DEF,
  parameter int TILE_SIZE   = TILE_SIZE_DEF,
  parameter int POS_W       = 9,
  parameter int START_X     = 8,
  parameter int START_Y     = 32,
  localparam int IDX_W      = (N_ACTORS > 1) ? $clog2(N_ACTORS) : 1,
  localparam int ADDR_W     = $clog2(MAP_STRIDE * MAP_H_TILES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_stb,
  input  logic [N_ACTORS-1:0]       want_valid,
  input  logic [2*N_ACTORS-1:0]     want_dir,
  input  logic [2*N_ACTORS-1:0]     speed,
  input  logic                      load_stb,
  input  logic [IDX_W-1:0]          load_idx,
  input  logic [POS_W-1:0]          load_x,
  input  logic [POS_W-1:0]          load_y,
  output logic                      map_rd_en,
  output logic [ADDR_W-1:0]         map_addr,
  input  logic [3:0]                map_data,
  output logic [POS_W*N_ACTORS-1:0] x_pos,
  output logic [POS_W*N_ACTORS-1:0] y_pos,
  output logic [2*N_ACTORS-1:0]     cur_dir,
  output logic [N_ACTORS-1:0]       stopped,
  output logic                      busy,
  output logic                      pass_done,
  output logic                      frame_overrun
);

  localparam int X_MAX = MAP_W_TILES * TILE_SIZE - 1;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] actor_reg, actor_next;
  logic [1:0]       step_reg, step_next;
  logic             move_ok_reg, move_ok_next;
  logic             pass_done_reg;
  logic             overrun_reg;

  // Flattened views of the per-actor registers for the selected-actor mux.
  logic [POS_W-1:0] x_arr   [N_ACTORS];
  logic [POS_W-1:0] y_arr   [N_ACTORS];
  direction_t       cur_arr [N_ACTORS];
  direction_t       nxt_arr [N_ACTORS];
  logic [1:0]       spd_arr [N_ACTORS];

  logic [POS_W-1:0] cur_x, cur_y, step_x, step_y;
  direction_t       cur_d, nxt_d, nb_dir;
  logic [1:0]       cur_spd;
  logic             aligned_x, aligned_y, axis_aligned, last_actor;
  logic [ADDR_W-1:0] nb_addr;
  logic             nb_oob;

  logic turn_accept, adv_en, pass_start, load_apply;

  assign cur_x   = x_arr[actor_reg];
  assign cur_y   = y_arr[actor_reg];
  assign cur_d   = cur_arr[actor_reg];
  assign nxt_d   = nxt_arr[actor_reg];
  assign cur_spd = spd_arr[actor_reg];

  assign aligned_x    = (cur_x & POS_W'(TILE_SIZE - 1)) == '0;
  assign aligned_y    = (cur_y & POS_W'(TILE_SIZE - 1)) == '0;
  // Bit 0 of the heading is set for RIGHT/LEFT.
  assign axis_aligned = cur_d[0] ? aligned_x : aligned_y;
  assign last_actor   = (actor_reg == IDX_W'(N_ACTORS - 1));
  assign load_apply   = (state_reg == ST_IDLE) && load_stb;

  // The turn check looks toward the buffered heading, everything else
  // looks along the current heading.
  assign nb_dir = (state_reg == ST_TURN_RD) ? nxt_d : cur_d;

  maze_neighbour_addr #(
    .MAP_W_TILES (MAP_W_TILES),
    .MAP_H_TILES (MAP_H_TILES),
    .MAP_STRIDE  (MAP_STRIDE),
    .TILE_SIZE   (TILE_SIZE),
    .POS_W       (POS_W),
    .ADDR_W      (ADDR_W)
  ) u_nb (
    .x    (cur_x),
    .y    (cur_y),
    .dir  (nb_dir),
    .addr (nb_addr),
    .oob  (nb_oob)
  );

  // One-pixel step of the selected actor; x wraps across the tunnel.
  always_comb begin
    step_x = cur_x;
    step_y = cur_y;
    unique case (cur_d)
      DIR_RIGHT: step_x = (cur_x >= POS_W'(X_MAX)) ? '0 : cur_x + 1'b1;
      DIR_LEFT:  step_x = (cur_x == '0) ? POS_W'(X_MAX) : cur_x - 1'b1;
      DIR_UP:    step_y = cur_y - 1'b1;
      DIR_DOWN:  step_y = cur_y + 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      actor_reg     <= '0;
      step_reg      <= '0;
      move_ok_reg   <= 1'b0;
      pass_done_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      actor_reg     <= actor_next;
      step_reg      <= step_next;
      move_ok_reg   <= move_ok_next;
      pass_done_reg <= (state_reg == ST_DONE);
      overrun_reg   <= frame_stb && (state_reg != ST_IDLE);
    end
  end

  always_comb begin
    state_next   = state_reg;
    actor_next   = actor_reg;
    step_next    = step_reg;
    move_ok_next = move_ok_reg;
    map_rd_en    = 1'b0;
    map_addr     = '0;
    turn_accept  = 1'b0;
    adv_en       = 1'b0;
    pass_start   = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (frame_stb) begin
          pass_start = 1'b1;
          actor_next = '0;
          step_next  = '0;
          state_next = ST_TURN_RD;
        end
      end
      ST_TURN_RD: begin
        if (cur_spd == 2'd0) begin
          // Parked actor: hop to the next one without touching it.
          if (last_actor) begin
            state_next = ST_DONE;
          end else begin
            actor_next = actor_reg + 1'b1;
            step_next  = '0;
          end
        end else if (nxt_d == cur_d) begin
          state_next = ST_MOVE_RD;
        end else if (nxt_d == reverse(cur_d)) begin
          turn_accept = 1'b1;
          state_next  = ST_MOVE_RD;
        end else if (aligned_x && aligned_y && !nb_oob) begin
          map_rd_en  = 1'b1;
          map_addr   = nb_addr;
          state_next = ST_TURN_WAIT;
        end else begin
          // Mid-tile or off-map turn: keep it buffered for a later step.
          state_next = ST_MOVE_RD;
        end
      end
      ST_TURN_WAIT: begin
        if (map_data == 4'd0) turn_accept = 1'b1;
        state_next = ST_MOVE_RD;
      end
      ST_MOVE_RD: begin
        if (!axis_aligned) begin
          move_ok_next = 1'b1;
          state_next   = ST_ADVANCE;
        end else if (nb_oob) begin
          move_ok_next = 1'b0;
          state_next   = ST_ADVANCE;
        end else begin
          map_rd_en  = 1'b1;
          map_addr   = nb_addr;
          state_next = ST_MOVE_WAIT;
        end
      end
      ST_MOVE_WAIT: begin
        move_ok_next = (map_data == 4'd0);
        state_next   = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        adv_en = 1'b1;
        if ({1'b0, step_reg} + 3'd1 < {1'b0, cur_spd}) begin
          step_next  = step_reg + 1'b1;
          state_next = ST_TURN_RD;
        end else if (last_actor) begin
          state_next = ST_DONE;
        end else begin
          actor_next = actor_reg + 1'b1;
          step_next  = '0;
          state_next = ST_TURN_RD;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_ACTORS; gi++) begin : g_actor
      logic [POS_W-1:0] x_reg;
      logic [POS_W-1:0] y_reg;
      direction_t       cur_dir_reg;
      direction_t       next_dir_reg;
      logic             stopped_reg;
      logic [1:0]       spd_reg;
      logic             sel;

      assign sel = (actor_reg == IDX_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_reg        <= POS_W'(START_X);
          y_reg        <= POS_W'(START_Y);
          cur_dir_reg  <= DIR_RIGHT;
          next_dir_reg <= DIR_RIGHT;
          stopped_reg  <= 1'b0;
          spd_reg      <= 2'd0;
        end else begin
          if (load_apply && (load_idx == IDX_W'(gi))) begin
            x_reg        <= load_x;
            y_reg        <= load_y;
            cur_dir_reg  <= DIR_RIGHT;
            next_dir_reg <= DIR_RIGHT;
            stopped_reg  <= 1'b0;
          end else begin
            if (want_valid[gi]) next_dir_reg <= direction_t'(want_dir[2*gi +: 2]);
            if (sel && turn_accept) cur_dir_reg <= next_dir_reg;
            if (sel && adv_en) begin
              if (move_ok_reg) begin
                x_reg       <= step_x;
                y_reg       <= step_y;
                stopped_reg <= 1'b0;
              end else begin
                stopped_reg <= 1'b1;
              end
            end
          end
          if (pass_start) spd_reg <= speed[2*gi +: 2];
        end
      end

      assign x_arr[gi]   = x_reg;
      assign y_arr[gi]   = y_reg;
      assign cur_arr[gi] = cur_dir_reg;
      assign nxt_arr[gi] = next_dir_reg;
      assign spd_arr[gi] = spd_reg;

      assign x_pos[POS_W*gi +: POS_W] = x_reg;
      assign y_pos[POS_W*gi +: POS_W] = y_reg;
      assign cur_dir[2*gi +: 2]       = cur_dir_reg;
      assign stopped[gi]              = stopped_reg;
    end
  endgenerate

  assign busy          = (state_reg != ST_IDLE);
  assign pass_done     = pass_done_reg;
  assign frame_overrun = overrun_reg;

endmodule

// File: tb/tb_maze_actor_mover.sv
// tb_maze_actor_mover
// Directed bench for maze_actor_mover with a behavioural map RAM.
// Expected actor states are queued as each frame is launched and
// compared once the pass completes.
module tb_maze_actor_mover;

  localparam int N     = 4;
  localparam int POS_W = 9;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           frame_stb;
  logic [N-1:0]   want_valid;
  logic [2*N-1:0] want_dir;
  logic [2*N-1:0] speed;
  logic           load_stb;
  logic [1:0]     load_idx;
  logic [8:0]     load_x;
  logic [8:0]     load_y;
  logic           map_rd_en;
  logic [10:0]    map_addr;
  logic [3:0]     map_data;
  logic [POS_W*N-1:0] x_pos;
  logic [POS_W*N-1:0] y_pos;
  logic [2*N-1:0] cur_dir;
  logic [N-1:0]   stopped;
  logic           busy;
  logic           pass_done;
  logic           frame_overrun;

  logic [3:0] map_mem [0:2047];
  int         rd_cnt = 0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int idx;
    int x;
    int y;
    int d;
    int st;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  maze_actor_mover dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_stb     (frame_stb),
    .want_valid    (want_valid),
    .want_dir      (want_dir),
    .speed         (speed),
    .load_stb      (load_stb),
    .load_idx      (load_idx),
    .load_x        (load_x),
    .load_y        (load_y),
    .map_rd_en     (map_rd_en),
    .map_addr      (map_addr),
    .map_data      (map_data),
    .x_pos         (x_pos),
    .y_pos         (y_pos),
    .cur_dir       (cur_dir),
    .stopped       (stopped),
    .busy          (busy),
    .pass_done     (pass_done),
    .frame_overrun (frame_overrun)
  );

  always @(posedge clk) begin
    if (map_rd_en) begin
      map_data <= map_mem[map_addr];
      rd_cnt   <= rd_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input int idx, input int x, input int y, input int d, input int st);
    exp_t e;
    e.idx = idx; e.x = x; e.y = y; e.d = d; e.st = st;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string label);
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      $display("%s actor=%0d x=%0d y=%0d dir=%0d stopped=%0d", label, e.idx,
               x_pos[POS_W*e.idx +: POS_W], y_pos[POS_W*e.idx +: POS_W],
               cur_dir[2*e.idx +: 2], stopped[e.idx]);
      check($sformatf("%s_x%0d", label, e.idx), 32'(x_pos[POS_W*e.idx +: POS_W]), e.x);
      check($sformatf("%s_y%0d", label, e.idx), 32'(y_pos[POS_W*e.idx +: POS_W]), e.y);
      check($sformatf("%s_dir%0d", label, e.idx), 32'(cur_dir[2*e.idx +: 2]), e.d);
      check($sformatf("%s_stop%0d", label, e.idx), 32'(stopped[e.idx]), e.st);
    end
  endtask

  task automatic pulse_frame();
    @(negedge clk); frame_stb = 1'b1;
    @(negedge clk); frame_stb = 1'b0;
    check("busy_rise", 32'(busy), 1);
  endtask

  task automatic wait_done();
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      if (pass_done) seen = 1'b1;
      n++;
    end
    check("pass_done_seen", 32'(seen), 1);
    check("busy_fall", 32'(busy), 0);
  endtask

  task automatic frame(input string label);
    pulse_frame();
    wait_done();
    drain(label);
  endtask

  task automatic do_load(input int idx, input int x, input int y);
    @(negedge clk);
    load_stb = 1'b1; load_idx = 2'(idx); load_x = 9'(x); load_y = 9'(y);
    @(negedge clk);
    load_stb = 1'b0;
  endtask

  task automatic set_want(input int idx, input int d);
    @(negedge clk);
    want_valid[idx]      = 1'b1;
    want_dir[2*idx +: 2] = 2'(d);
    @(negedge clk);
    want_valid = '0;
  endtask

  initial begin
    int rd0;
    int busy_cycles;
    for (int i = 0; i < 2048; i++) map_mem[i] = 4'd0;
    rst_n = 1'b0; frame_stb = 1'b0; want_valid = '0; want_dir = '0;
    speed = '0; load_stb = 1'b0; load_idx = '0; load_x = '0; load_y = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", 32'(busy), 0);
    check("rst_pass_done", 32'(pass_done), 0);
    check("rst_overrun", 32'(frame_overrun), 0);
    check("rst_rd_en", 32'(map_rd_en), 0);
    check("rst_addr", 32'(map_addr), 0);
    for (int a = 0; a < N; a++) push_exp(a, 8, 32, 1, 0);
    drain("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Open corridor: actor 0 speed 1 for 8 frames; one read at x=8 only
    speed = 8'b00_00_00_01;
    rd0 = rd_cnt;
    for (int f = 1; f <= 8; f++) begin
      push_exp(0, 8 + f, 32, 1, 0);
      frame("corridor");
    end
    check("corridor_reads", rd_cnt - rd0, 1);

    // Wall ahead at tile (2,4): actor stays at x=8 and reports stopped
    map_mem[2 + 4*32] = 4'd1;
    do_load(0, 8, 32);
    for (int f = 0; f < 3; f++) begin
      push_exp(0, 8, 32, 1, 1);
      frame("wall");
    end
    map_mem[2 + 4*32] = 4'd0;

    // Buffered UP turn taken only once tile-aligned at x=16
    do_load(0, 12, 32);
    set_want(0, 0);
    rd0 = rd_cnt;
    for (int f = 1; f <= 4; f++) begin
      push_exp(0, 12 + f, 32, 1, 0);
      frame("turn_wait");
    end
    check("turn_midtile_reads", rd_cnt - rd0, 0);
    push_exp(0, 16, 31, 0, 0);
    frame("turn_up");
    check("turn_reads", rd_cnt - rd0, 2);
    push_exp(0, 16, 30, 0, 0);
    frame("turn_up2");

    // Instant reversal mid-tile, no lookup
    do_load(0, 13, 32);
    set_want(0, 3);
    rd0 = rd_cnt;
    push_exp(0, 12, 32, 3, 0);
    frame("reverse");
    check("reverse_reads", rd_cnt - rd0, 0);

    // Tunnel wrap on row 17
    do_load(0, 0, 136);
    set_want(0, 3);
    push_exp(0, 223, 136, 3, 0);
    frame("tunnel_l");
    set_want(0, 1);
    push_exp(0, 0, 136, 1, 0);
    frame("tunnel_r");

    // Per-actor speed: actor 1 at 3 px/frame, actor 0 parked
    speed = 8'b00_00_11_00;
    push_exp(0, 0, 136, 1, 0);
    push_exp(1, 11, 32, 1, 0);
    push_exp(2, 8, 32, 1, 0);
    push_exp(3, 8, 32, 1, 0);
    frame("speed");

    // Second pass with a frame_stb while busy: overrun pulse, no extra pass
    push_exp(0, 0, 136, 1, 0);
    push_exp(1, 14, 32, 1, 0);
    pulse_frame();
    @(negedge clk); frame_stb = 1'b1;
    @(negedge clk); frame_stb = 1'b0;
    check("overrun_pulse", 32'(frame_overrun), 1);
    @(negedge clk);
    check("overrun_single", 32'(frame_overrun), 0);
    wait_done();
    busy_cycles = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    check("no_extra_pass", busy_cycles, 0);
    drain("overrun");

    // Reset in the middle of a pass
    pulse_frame();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_rd_en", 32'(map_rd_en), 0);
    check("midrst_addr", 32'(map_addr), 0);
    push_exp(0, 8, 32, 1, 0);
    push_exp(1, 8, 32, 1, 0);
    drain("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
